// File: rtl/ifetch_queue.sv
// ifetch_queue: credit-based fetch response queue between core and I-memory.
// Optional macro IFETCH_QUEUE_BYPASS_EN lets a response skip an empty queue.
module ifetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_rd_i,
    input  logic [31:0] core_pc_i,
    input  logic        core_flush_i,
    input  logic        core_invalidate_i,
    output logic        core_accept_o,
    output logic        core_valid_o,
    input  logic        core_ready_i,
    output logic [63:0] core_inst_o,
    output logic        core_error_o,
    output logic        mem_i_rd_o,
    output logic [31:0] mem_i_pc_o,
    output logic        mem_i_flush_o,
    output logic        mem_i_invalidate_o,
    input  logic        mem_i_accept_i,
    input  logic        mem_i_valid_i,
    input  logic        mem_i_error_i,
    input  logic [63:0] mem_i_inst_i
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0]   LIMIT = (CW+1)'(DEPTH);
    localparam logic [CW-1:0] FULL  = CW'(DEPTH);

    logic [CW-1:0] inflight_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] discard_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [64:0]   ram_q [DEPTH];

    logic [CW:0]   credit_used;
    logic [CW-1:0] inflight_d;
    logic          push;
    logic          pop;
    logic          bypass;
    logic [64:0]   head;

    assign credit_used = {1'b0, inflight_q} + {1'b0, count_q};

    assign mem_i_rd_o = core_rd_i && !core_flush_i
                        && (credit_used < LIMIT);
    assign mem_i_pc_o         = core_pc_i;
    assign mem_i_flush_o      = core_flush_i;
    assign mem_i_invalidate_o = core_invalidate_i;
    assign core_accept_o      = mem_i_rd_o && mem_i_accept_i;

`ifdef IFETCH_QUEUE_BYPASS_EN
    assign bypass = (count_q == '0) && (discard_q == '0)
                    && mem_i_valid_i && core_ready_i
                    && !core_flush_i;
`else
    assign bypass = 1'b0;
`endif

    assign push = mem_i_valid_i && !core_flush_i
                  && (discard_q == '0) && !bypass;
    assign pop  = (count_q != '0) && core_ready_i;

    // A flush cycle never accepts, so this is also the discard target.
    assign inflight_d = inflight_q + CW'(core_accept_o)
                        - CW'(mem_i_valid_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight_q <= '0;
            count_q    <= '0;
            discard_q  <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else if (core_flush_i) begin
            inflight_q <= inflight_d;
            discard_q  <= inflight_d;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            inflight_q <= inflight_d;
            if (mem_i_valid_i && (discard_q != '0))
                discard_q <= discard_q - 1'b1;
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push)
            ram_q[wr_ptr_q] <= {mem_i_error_i, mem_i_inst_i};
    end

    assign head = (count_q != '0) ? ram_q[rd_ptr_q] : '0;

`ifdef IFETCH_QUEUE_BYPASS_EN
    assign core_valid_o = (count_q != '0) || bypass;
    assign core_inst_o  = bypass ? mem_i_inst_i : head[63:0];
    assign core_error_o = bypass ? mem_i_error_i : head[64];
`else
    assign core_valid_o = (count_q != '0);
    assign core_inst_o  = head[63:0];
    assign core_error_o = head[64];
`endif

    // Credit accounting makes a push into a full queue unreachable.
    assert property (@(posedge clk_i) disable iff (rst_i)
        !(push && !pop && (count_q == FULL)));

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomized and directed bench for ifetch_queue against a queue-level
// model of in-flight fetches and delivered responses.
module tb_ifetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        core_rd_i = 1'b0;
    logic [31:0] core_pc_i = '0;
    logic        core_flush_i = 1'b0;
    logic        core_invalidate_i = 1'b0;
    logic        core_accept_o;
    logic        core_valid_o;
    logic        core_ready_i = 1'b0;
    logic [63:0] core_inst_o;
    logic        core_error_o;
    logic        mem_i_rd_o;
    logic [31:0] mem_i_pc_o;
    logic        mem_i_flush_o;
    logic        mem_i_invalidate_o;
    logic        mem_i_accept_i = 1'b0;
    logic        mem_i_valid_i = 1'b0;
    logic        mem_i_error_i = 1'b0;
    logic [63:0] mem_i_inst_i = '0;

    always #5 clk = ~clk;

    ifetch_queue #(.DEPTH(DEPTH)) dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .core_rd_i          (core_rd_i),
        .core_pc_i          (core_pc_i),
        .core_flush_i       (core_flush_i),
        .core_invalidate_i  (core_invalidate_i),
        .core_accept_o      (core_accept_o),
        .core_valid_o       (core_valid_o),
        .core_ready_i       (core_ready_i),
        .core_inst_o        (core_inst_o),
        .core_error_o       (core_error_o),
        .mem_i_rd_o         (mem_i_rd_o),
        .mem_i_pc_o         (mem_i_pc_o),
        .mem_i_flush_o      (mem_i_flush_o),
        .mem_i_invalidate_o (mem_i_invalidate_o),
        .mem_i_accept_i     (mem_i_accept_i),
        .mem_i_valid_i      (mem_i_valid_i),
        .mem_i_error_i      (mem_i_error_i),
        .mem_i_inst_i       (mem_i_inst_i)
    );

    typedef struct {
        logic [31:0] pc;
        bit          err;
        bit          drop;
    } ent_t;

    ent_t        mq[$];
    logic [64:0] fq[$];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_acc;
    int          n_dlv;
    logic [31:0] pc;
    bit          emode;
    bit          got;
    logic [31:0] first_pc;
    bit          last_v;

`ifdef IFETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(bit rst, bit rd, bit rdy, bit macc,
                        bit mv, bit fl, bit inv);
        ent_t        e;
        bit          mvalid;
        bit          byp;
        bit          exp_rd;
        bit          exp_acc;
        bit          exp_v;
        logic [64:0] exp_h;
        @(negedge clk);
        mvalid = mv && (mq.size() > 0);
        rst_i = rst;
        core_rd_i = rd;
        core_pc_i = pc;
        core_flush_i = fl;
        core_invalidate_i = inv;
        core_ready_i = rdy;
        mem_i_accept_i = macc;
        mem_i_valid_i = mvalid;
        if (mvalid) begin
            e = mq[0];
            mem_i_inst_i = {~e.pc, e.pc};
            mem_i_error_i = e.err;
        end else begin
            mem_i_inst_i = {$urandom, $urandom};
            mem_i_error_i = 1'($urandom);
        end
        exp_rd = rd && !fl && (mq.size() + fq.size() < DEPTH);
        exp_acc = exp_rd && macc;
        byp = BYP && (fq.size() == 0) && mvalid && rdy
              && !fl && !e.drop;
        exp_v = byp || (fq.size() > 0);
        if (byp)
            exp_h = {e.err, ~e.pc, e.pc};
        else if (fq.size() > 0)
            exp_h = fq[0];
        else
            exp_h = '0;
        #1;
        if (!rst) begin
            chk("mem_rd", 64'(mem_i_rd_o), 64'(exp_rd));
            chk("accept", 64'(core_accept_o), 64'(exp_acc));
            chk("valid", 64'(core_valid_o), 64'(exp_v));
            chk("inst", core_inst_o, exp_h[63:0]);
            chk("error", 64'(core_error_o), 64'(exp_h[64]));
            chk("mem_pc", 64'(mem_i_pc_o), 64'(pc));
            chk("mem_flush", 64'(mem_i_flush_o), 64'(fl));
            chk("mem_inval", 64'(mem_i_invalidate_o), 64'(inv));
            if (core_accept_o)
                n_acc++;
            if (core_valid_o && rdy) begin
                n_dlv++;
                if (!got) begin
                    got = 1'b1;
                    first_pc = core_inst_o[31:0];
                end
            end
            last_v = core_valid_o;
        end
        @(posedge clk);
        if (rst) begin
            mq.delete();
            fq.delete();
        end else begin
            if (!byp && (fq.size() > 0) && rdy)
                void'(fq.pop_front());
            if (mvalid) begin
                e = mq.pop_front();
                if (!fl && !e.drop && !byp)
                    fq.push_back({e.err, ~e.pc, e.pc});
            end
            if (fl) begin
                fq.delete();
                foreach (mq[i]) mq[i].drop = 1'b1;
            end
            if (exp_acc) begin
                e.pc = pc;
                e.err = emode ? ($urandom_range(5) == 0)
                              : (pc == 32'h8000_0010);
                e.drop = 1'b0;
                mq.push_back(e);
                pc = pc + 32'd8;
            end
        end
    endtask

    initial begin
        pc = 32'h8000_0000;
        emode = 1'b0;
        got = 1'b0;
        first_pc = '0;
        repeat (3) step(1, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_valid", 64'(core_valid_o), 64'd0);
        chk("rst_inst", core_inst_o, 64'd0);
        chk("rst_error", 64'(core_error_o), 64'd0);

        n_acc = 0;
        n_dlv = 0;
        repeat (8) step(0, 1, 1, 1, 1, 0, 0);
        repeat (3) step(0, 0, 1, 1, 1, 0, 0);
        chk("stream_acc", 64'(n_acc), 64'd8);
        chk("stream_dlv", 64'(n_dlv), 64'd8);

        n_acc = 0;
        repeat (10) step(0, 1, 0, 1, 1, 0, 0);
        chk("bp_acc", 64'(n_acc), 64'(DEPTH));
        n_acc = 0;
        n_dlv = 0;
        repeat (4) step(0, 1, 1, 1, 0, 0, 0);
        chk("bp_dlv", 64'(n_dlv), 64'(DEPTH));
        chk("bp_resume", 64'(n_acc > 0), 64'd1);
        repeat (8) step(0, 0, 1, 1, 1, 0, 0);

        pc = 32'h8000_0040;
        step(0, 1, 0, 1, 0, 0, 0);
        step(0, 1, 0, 1, 1, 0, 0);
        step(0, 1, 0, 1, 0, 0, 0);
        step(0, 1, 0, 1, 0, 1, 0);
        pc = 32'h8000_0100;
        got = 1'b0;
        step(0, 1, 1, 1, 1, 0, 0);
        repeat (4) step(0, 0, 1, 1, 1, 0, 0);
        chk("flush_next_pc", 64'(first_pc), 64'h8000_0100);

        pc = 32'h8000_0200;
        step(0, 1, 1, 1, 0, 0, 0);
        step(0, 0, 1, 1, 1, 1, 0);
        pc = 32'h8000_0300;
        got = 1'b0;
        step(0, 1, 1, 1, 0, 0, 0);
        repeat (4) step(0, 0, 1, 1, 1, 0, 0);
        chk("flush_resp_pc", 64'(first_pc), 64'h8000_0300);

        pc = 32'h8000_0400;
        step(0, 1, 1, 1, 0, 0, 0);
        step(0, 0, 1, 1, 1, 0, 0);
        chk("lat_same", 64'(last_v), 64'(BYP));
        step(0, 0, 1, 1, 0, 0, 0);
        chk("lat_next", 64'(last_v), 64'(!BYP));

        emode = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(7) == 0)
                pc = $urandom;
            if (i == 200)
                step(1, 0, 0, 0, 0, 0, 0);
            else
                step(0, ($urandom_range(3) != 0),
                     ($urandom_range(2) != 0),
                     ($urandom_range(3) != 0),
                     ($urandom_range(2) != 0),
                     ($urandom_range(15) == 0),
                     ($urandom_range(7) == 0));
        end
        repeat (10) step(0, 0, 1, 1, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, response queue entries; power of two, range 2..16.
REQ-002 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_i  in  1  reset, synchronous, active-high.
REQ-004 core_rd_i  in  1  core fetch request.
REQ-005 core_pc_i  in  32  fetch address; bits [2:0] passed unmodified.
REQ-006 core_flush_i  in  1  single-cycle pulse; discard all pending fetches.
REQ-007 core_invalidate_i  in  1  instruction invalidate request, passed through.
REQ-008 core_accept_o  out  1  request taken this cycle.
REQ-009 core_valid_o  out  1  response available at queue head.
REQ-010 core_ready_i  in  1  core consumes head when core_valid_o && core_ready_i.
REQ-011 core_inst_o  out  64  head instruction pair.
REQ-012 core_error_o  out  1  head fetch error.
REQ-013 mem_i_rd_o, mem_i_pc_o[31:0], mem_i_flush_o, mem_i_invalidate_o  out  memory-side request.
REQ-014 mem_i_accept_i, mem_i_valid_i, mem_i_error_i, mem_i_inst_i[63:0]  in  memory-side response; no backpressure, valid_i consumed unconditionally.

Function
REQ-015 Credit rule: inflight (accepted, unreturned) + count (queued) SHALL never exceed DEPTH; both counters are clog2(DEPTH)+1 bits.
REQ-016 mem_i_rd_o = core_rd_i && !core_flush_i && (inflight+count < DEPTH); mem_i_pc_o = core_pc_i combinationally.
REQ-017 core_accept_o = mem_i_rd_o && mem_i_accept_i; inflight increments on this.
REQ-018 inflight decrements on each mem_i_valid_i; simultaneous accept and return leave it unchanged.
REQ-019 Returned response with discard==0 is written to queue tail as {error, inst}; with discard>0 it is dropped and discard decrements.
REQ-020 Queue is in-order FIFO with wrapping read/write pointers mod DEPTH; simultaneous push and pop when full or empty SHALL be legal and leave count unchanged.
REQ-021 Push into a full queue is impossible by REQ-015; implementation SHALL flag it only via simulation assertion.
REQ-022 Head outputs: core_valid_o = (count != 0); core_inst_o/core_error_o = head entry (zero when empty).
REQ-023 On core_flush_i: queue emptied (count=0, pointers reset), discard <= inflight after the same-cycle update excluding any new accept (none possible per REQ-016), mem_i_flush_o = core_flush_i same cycle.
REQ-024 Flush coinciding with mem_i_valid_i: that response is dropped and not counted in discard.
REQ-025 Requests after flush are accepted while discard>0; their responses follow discarded ones in order.
REQ-026 mem_i_invalidate_o = core_invalidate_i combinationally.
REQ-027 Minimum latency mem_i_valid_i -> core_valid_o: one cycle (registered queue), unless REQ-031 applies.

Reset
REQ-028 On rst_i: inflight, count, discard, pointers = 0; core_valid_o, core_error_o = 0; core_inst_o = 0.
REQ-029 Reset mid-operation SHALL abandon all in-flight fetches; memory side is reset by the same rst_i, so no post-reset responses are expected.
REQ-030 Queue storage contents need not be reset.

Configuration
REQ-031 IFETCH_QUEUE_BYPASS_EN defined: when queue empty, discard==0, mem_i_valid_i and core_ready_i, response drives core outputs in the same cycle and is not pushed; core_valid_o also asserts with empty queue in that case.
REQ-032 IFETCH_QUEUE_BYPASS_EN undefined: all responses pass through the queue; core outputs are purely registered-state driven.

Verification
REQ-033 Streaming: core_rd_i=1, ready=1, mem accepts every cycle, 1-cycle memory -> 8 consecutive PCs 0x80000000+8n delivered in order, no gaps after fill.
REQ-034 Backpressure: core_ready_i=0 for 10 cycles, DEPTH=4 -> exactly 4 accepts then core_accept_o=0; releasing ready delivers 4 entries in order, accepts resume.
REQ-035 Flush with 2 inflight, 1 queued -> core_valid_o=0 next cycle, next 2 mem responses dropped, third (new PC 0x80000100) delivered.
REQ-036 Flush same cycle as mem_i_valid_i with inflight=1 -> response dropped, discard=0, following response delivered.
REQ-037 Error: mem_i_error_i=1 on PC 0x80000010 -> core_error_o=1 with that entry only; adjacent entries error=0.
REQ-038 Bypass build: empty queue, ready=1, single response -> core_valid_o same cycle as mem_i_valid_i; without macro, one cycle later.
